// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one genrom read port between the fetch (F) and load (D) units.
// Each access runs IDLE -> WAIT (LATENCY cycles) -> DONE (one-cycle ack).
module mem_port_arbiter #(
  parameter int AW = 4,
  parameter int EXTRA = 4,
  parameter int LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    f_req,
  input  logic [AW:0]             f_addr,
  input  logic [EXTRA-1:0]        f_extra,
  input  logic [AW:0]             f_lower,
  input  logic [AW:0]             f_upper,
  output logic                    f_ack,
  output logic [2**EXTRA*8-1:0]   f_data,
  output logic                    f_error,
  input  logic                    d_req,
  input  logic [AW:0]             d_addr,
  input  logic [EXTRA-1:0]        d_extra,
  input  logic [AW:0]             d_lower,
  input  logic [AW:0]             d_upper,
  output logic                    d_ack,
  output logic [2**EXTRA*8-1:0]   d_data,
  output logic                    d_error,
  output logic [AW:0]             mem_addr,
  output logic [EXTRA-1:0]        mem_extra,
  output logic [AW:0]             mem_lower_bound,
  output logic [AW:0]             mem_upper_bound,
  input  logic [2**EXTRA*8-1:0]   mem_data,
  input  logic                    mem_error,
  output logic                    busy,
  output logic                    grant
);
  localparam int DW = (2**EXTRA)*8;
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic grant_q, grant_d, last_q, last_d, sel;
  logic [AW:0] addr_q, addr_d, lo_q, lo_d, hi_q, hi_d;
  logic [EXTRA-1:0] extra_q, extra_d;
  logic [DW-1:0] f_data_q, f_data_d, d_data_q, d_data_d;
  logic f_err_q, f_err_d, d_err_q, d_err_d, f_ack_q, f_ack_d, d_ack_q, d_ack_d;

  // On a tie the requester that did not win last time gets the port.
  assign sel = (f_req && d_req) ? ~last_q : d_req;

  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    grant_d = grant_q;
    last_d = last_q;
    addr_d = addr_q;
    extra_d = extra_q;
    lo_d = lo_q;
    hi_d = hi_q;
    f_data_d = f_data_q;
    d_data_d = d_data_q;
    f_err_d = f_err_q;
    d_err_d = d_err_q;
    f_ack_d = 1'b0;
    d_ack_d = 1'b0;
    case (state_q)
      IDLE: if (f_req || d_req) begin
        state_d = WAIT;
        cnt_d = 3'(LATENCY);
        grant_d = sel;
        last_d = sel;
        addr_d = sel ? d_addr : f_addr;
        extra_d = sel ? d_extra : f_extra;
        lo_d = sel ? d_lower : f_lower;
        hi_d = sel ? d_upper : f_upper;
      end
      WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          state_d = DONE;
          f_ack_d = ~grant_q;
          d_ack_d = grant_q;
          f_data_d = grant_q ? f_data_q : mem_data;
          f_err_d = grant_q ? f_err_q : mem_error;
          d_data_d = grant_q ? mem_data : d_data_q;
          d_err_d = grant_q ? mem_error : d_err_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      grant_q <= 1'b0;
      last_q <= 1'b1;
      addr_q <= '0;
      extra_q <= '0;
      lo_q <= '0;
      hi_q <= '0;
      f_data_q <= '0;
      d_data_q <= '0;
      f_err_q <= 1'b0;
      d_err_q <= 1'b0;
      f_ack_q <= 1'b0;
      d_ack_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      grant_q <= grant_d;
      last_q <= last_d;
      addr_q <= addr_d;
      extra_q <= extra_d;
      lo_q <= lo_d;
      hi_q <= hi_d;
      f_data_q <= f_data_d;
      d_data_q <= d_data_d;
      f_err_q <= f_err_d;
      d_err_q <= d_err_d;
      f_ack_q <= f_ack_d;
      d_ack_q <= d_ack_d;
    end
  end

  assign f_ack = f_ack_q;
  assign d_ack = d_ack_q;
  assign f_data = f_data_q;
  assign d_data = d_data_q;
  assign f_error = f_err_q;
  assign d_error = d_err_q;
  assign mem_addr = addr_q;
  assign mem_extra = extra_q;
  assign mem_lower_bound = lo_q;
  assign mem_upper_bound = hi_q;
  assign busy = state_q != IDLE;
  assign grant = grant_q;
endmodule
